// File: rtl/fn_sweep_ctrl.sv
// fn_sweep_ctrl: sweeps all 16 {sel,b,a} vectors of the 4-function
// logic unit, builds the truth table from y_in and counts misses.
// Ports: clk, rst (async high), start, abort, y_in -> a, b, sel,
//        busy, done, result[15:0], err_cnt[4:0], pass.
module fn_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  err_cnt,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam logic [15:0] GOLD  = 16'h96E8;
  localparam logic [2:0]  CLAST = 3'(SETTLE - 1);

  state_t      state;
  state_t      nstate;
  logic [3:0]  idx;
  logic [2:0]  cnt;
  logic        smp;
  logic        miss;
  logic [4:0]  err_nxt;

  // smp marks the edge that ends the last settle cycle of a vector;
  // abort suppresses it so the pending sample is dropped.
  always_comb begin
    nstate = state;
    smp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nstate = DRIVE;
      end
      DRIVE: begin
        if (abort) begin
          nstate = IDLE;
        end else if (cnt == CLAST) begin
          smp = 1'b1;
          if (idx == 4'd15) nstate = DONE;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  assign miss    = (y_in != GOLD[idx]);
  assign err_nxt = err_cnt + {4'd0, smp & miss};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      result  <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            cnt     <= '0;
            result  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
          end
        end
        DRIVE: begin
          if (smp) begin
            result[idx] <= y_in;
            err_cnt     <= err_nxt;
            cnt         <= '0;
            // the last vector stays on a/b/sel through DONE
            if (idx != 4'd15) idx <= idx + 4'd1;
            else              pass <= (err_nxt == 5'd0);
          end else if (!abort) begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // idx is a register, so the operand outputs are registered too
  assign a    = idx[0];
  assign b    = idx[1];
  assign sel  = idx[3:2];
  assign busy = (state == DRIVE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// tb_fn_sweep_ctrl: directed bench for fn_sweep_ctrl, two instances
// (SETTLE=1 and SETTLE=3) each fed by a selectable logic-unit model.
module tb_fn_sweep_ctrl;

  localparam logic [15:0] GOLD = 16'h96E8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st   [2];
  logic        ab   [2];
  logic        y    [2];
  logic        a_o  [2];
  logic        b_o  [2];
  logic [1:0]  sel_o[2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] res  [2];
  logic [4:0]  err  [2];
  logic        pass [2];
  int          mode [2];

  int nchk = 0;
  int nbad = 0;
  bit cur  = 1'b0;

  always #5 clk = ~clk;

  fn_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .y_in(y[0]),
    .a(a_o[0]), .b(b_o[0]), .sel(sel_o[0]), .busy(busy[0]),
    .done(done[0]), .result(res[0]), .err_cnt(err[0]), .pass(pass[0])
  );

  fn_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .y_in(y[1]),
    .a(a_o[1]), .b(b_o[1]), .sel(sel_o[1]), .busy(busy[1]),
    .done(done[1]), .result(res[1]), .err_cnt(err[1]), .pass(pass[1])
  );

  function automatic logic unit(input int m, input logic [1:0] s,
                                input logic bb, input logic aa);
    logic f;
    case (s)
      2'b00:   f = aa & bb;
      2'b01:   f = aa | bb;
      2'b10:   f = aa ^ bb;
      default: f = ~(aa ^ bb);
    endcase
    if (m == 1) return 1'b0;
    if (m == 2) return ~f;
    return f;
  endfunction

  assign y[0] = unit(mode[0], sel_o[0], b_o[0], a_o[0]);
  assign y[1] = unit(mode[1], sel_o[1], b_o[1], a_o[1]);

  logic [3:0]  vec_c;
  logic        busy_c;
  logic        done_c;
  logic [15:0] res_c;
  logic [4:0]  err_c;
  logic        pass_c;

  assign vec_c  = {sel_o[cur], b_o[cur], a_o[cur]};
  assign busy_c = busy[cur];
  assign done_c = done[cur];
  assign res_c  = res[cur];
  assign err_c  = err[cur];
  assign pass_c = pass[cur];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic sweep(input bit d, input int m, input bit both,
                       input int cyc, input logic [15:0] er,
                       input logic [4:0] ee, input logic ep);
    int n;
    int bad;
    int s;
    s   = d ? 3 : 1;
    cur = d;
    mode[d] = m;
    @(negedge clk);
    st[d] = 1'b1;
    ab[d] = both;
    @(posedge clk);
    @(negedge clk);
    st[d] = 1'b0;
    ab[d] = 1'b0;
    chk("busy_on", busy_c, 1);
    chk("pass_clr", pass_c, 0);
    n   = 0;
    bad = 0;
    while (!done_c && n < 400) begin
      if (vec_c != 4'(n / s)) bad++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, cyc);
    chk("vec_hold", bad, 0);
    chk("last_vec", vec_c, 15);
    chk("result", res_c, er);
    chk("err_cnt", err_c, ee);
    chk("pass", pass_c, ep);
    @(posedge clk);
    @(negedge clk);
    chk("idle", {busy_c, done_c}, 0);
    chk("res_hold", res_c, er);
    chk("err_hold", err_c, ee);
  endtask

  initial begin
    int dn;
    st[0] = 0; st[1] = 0; ab[0] = 0; ab[1] = 0;
    mode[0] = 0; mode[1] = 0;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_vec", {sel_o[0], b_o[0], a_o[0]}, 0);
    chk("rst_res", res[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_pass", pass[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // correct model, start and abort together in IDLE
    sweep(0, 0, 1, 16, GOLD, 5'd0, 1'b1);
    // y tied low
    sweep(0, 1, 0, 16, 16'h0000, 5'd8, 1'b0);
    // inverted model
    sweep(0, 2, 0, 16, 16'h6917, 5'd16, 1'b0);

    // abort on the 6th DRIVE cycle
    cur = 0;
    mode[0] = 0;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    ab[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ab[0] = 1'b0;
    chk("ab_busy", busy[0], 0);
    chk("ab_done", done[0], 0);
    chk("ab_res", res[0], 16'h0008);
    chk("ab_err", err[0], 0);
    chk("ab_pass", pass[0], 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    chk("ab_nodone", dn, 0);

    // start re-pulsed mid-sweep, then async reset
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    chk("restart_ign", {busy[0], sel_o[0], b_o[0], a_o[0]}, 5'h13);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {busy[0], done[0]}, 0);
    chk("arst_vec", {sel_o[0], b_o[0], a_o[0]}, 0);
    chk("arst_res", res[0], 0);
    chk("arst_err", err[0], 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 0, 0, 16, GOLD, 5'd0, 1'b1);

    // SETTLE=3 instance
    sweep(1, 0, 0, 48, GOLD, 5'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule
